tdm_demux: RTL and testbench
============================

# tdm_demux

Receive-side demultiplexer for the team's time-division shared line, where a select-driven tri-state mux places one lane bit per slot onto a single wire. The block aligns to the frame marker, counts slots, and steers each received bit into its lane. It then presents a complete, registered lane word once per frame with a one-cycle valid strobe. It sits directly behind the shared-line receiver and feeds lane-parallel consumers.

## Interface
- `LANES`, default 4: lanes per frame, which is also data slots per frame. Must be at least 2.
- `SW`, default `$clog2(LANES+1)`: slot counter width. Derived; do not override.
- `clk` in, 1 bit: single clock, rising-edge.
- `rst_n` in, 1 bit: reset, asynchronous and active-low.
- `din` in, 1 bit: serial slot bit from the shared line.
- `din_vld` in, 1 bit: `din`/`fsync` are meaningful this cycle. When low, the cycle is ignored entirely (stall).
- `fsync` in, 1 bit: marks the current accepted bit as slot 0.
- `lanes` out, `LANES` bits: last complete frame. Bit *i* is slot *i*.
- `frame_vld` out, 1 bit: one-cycle pulse when `lanes` updates.
- `locked` out, 1 bit: high while in state LOCKED.
- `sync_err` out, 1 bit: one-cycle pulse on frame-alignment loss.

## Operation
- An accepted cycle is one where `din_vld`=1. Only accepted cycles change the slot counter, shadow or state.
- **HUNT**
  - Reset state.
  - Accepted bits are ignored until an accepted cycle with `fsync`=1.
  - On that cycle: shadow[0] ← `din`, slot counter ← 1, go to LOCKED.
- **LOCKED**
  - Accepted bit at slot *k* (1 ≤ *k* ≤ last) is written to shadow[*k*], and the counter increments.
  - On the last data slot (*k*=`LANES`−1): `lanes` ← {`din`, shadow[`LANES`−2:0]}, `frame_vld` pulses, counter ← 0.
  - At counter 0, `fsync`=1 is required. Shadow[0] ← `din`, counter ← 1.
- Boundary conditions:
  - **`fsync`=1 at nonzero slot:** `sync_err` pulses. The partial frame is discarded and `lanes` is unchanged. The current bit is taken as slot 0 (counter ← 1), and the block stays LOCKED.
  - **`fsync`=0 at slot 0 while LOCKED:** `sync_err` pulses, the bit is discarded, and the block goes to HUNT.
  - **`fsync` on the last data slot:** treated as misaligned, per the nonzero-slot rule. No `frame_vld` is produced.
  - **`din_vld` low mid-frame:** counter and shadow hold indefinitely.
- `lanes` holds its value between frames and is never partially updated.
- `rst_n` asserted mid-frame: immediate return to HUNT with all outputs cleared. The partial frame is lost.

## Timing
- Reset values:
  - `lanes`=0
  - `frame_vld`=0
  - `sync_err`=0
  - `locked`=0
  - `parity_err`=0
  - counter=0
  - state HUNT
- All outputs are registered.
- `lanes` and `frame_vld` become visible the cycle after the rising edge that samples the last data bit (one-cycle latency).
- `sync_err` appears the cycle after the offending accepted edge.
- `locked` rises the cycle after the first accepted `fsync`.
- At full rate (`din_vld` held high), `frame_vld` pulses every `LANES` cycles (`LANES`+1 with parity).

## Configuration
- Macro: `TDM_DEMUX_PARITY_EN`.
- **Defined:**
  - Each frame carries one extra slot, index `LANES`, holding even parity: the XOR of all lane bits and the parity bit equals 0.
  - `lanes` and `frame_vld` update on the parity slot instead of the last data slot.
  - Output `parity_err` (1 bit) pulses together with `frame_vld` on mismatch. `lanes` still updates.
  - `fsync` on the parity slot follows the misalignment rule.
- **Undefined:** no parity slot and no `parity_err` port. Frame length is `LANES`.

## Structure
- Package `tdm_pkg` holds:
  - state enum `tdm_state_e` {HUNT, LOCKED}
  - `TDM_LANES_DEF`=4
  - localparam function for frame length (`LANES` or `LANES`+1)
- Single module, no sub-module. Counter, shadow and state FSM are tightly coupled.

## Test plan
- Reset, then `fsync`+bits 1,0,1,1 on slots 0–3 → next cycle `lanes`=4'b1101, `frame_vld`=1 for one cycle, `locked`=1.
- Two back-to-back frames 4'hA, then 4'h5 at full rate → `frame_vld` pulses 4 cycles apart, `lanes`=A then 5.
- Frame with `din_vld` low for 3 cycles between slots 1 and 2 → same `lanes` result, `frame_vld` delayed by exactly 3 cycles.
- `fsync` at slot 2 → `sync_err` pulse, `lanes` unchanged, following 3 bits complete a new frame aligned to that `fsync`.
- Missing `fsync` at slot 0 → `sync_err` pulse, `locked`=0; bits without `fsync` ignored, and the next `fsync` relocks.
- With `TDM_DEMUX_PARITY_EN`: data 4'b0111, parity 1 → `parity_err`=0. Then parity 0 → `parity_err`=1 with `frame_vld`. Separately, `rst_n` mid-frame → all outputs 0.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the TDM receive-side demultiplexer.
// Frame length grows by one parity slot when TDM_DEMUX_PARITY_EN is defined.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_e;

  localparam int TDM_LANES_DEF = 4;

  // Slots per frame: data slots plus the optional trailing parity slot.
  function automatic int tdm_frame_len(input int lanes);
`ifdef TDM_DEMUX_PARITY_EN
    return lanes + 1;
`else
    return lanes;
`endif
  endfunction

endpackage

// File: rtl/tdm_demux.sv
// TDM demultiplexer: aligns to fsync, steers slot bits into lanes, emits one lane word per frame.
// Optional even-parity slot and parity_err output when TDM_DEMUX_PARITY_EN is defined.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int LANES = TDM_LANES_DEF,
  parameter int SW    = $clog2(LANES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_vld,
  input  logic             fsync,
  output logic [LANES-1:0] lanes,
  output logic             frame_vld,
  output logic             locked,
`ifdef TDM_DEMUX_PARITY_EN
  output logic             parity_err,
`endif
  output logic             sync_err
);

  localparam int            FRAME_LEN = tdm_frame_len(LANES);
  localparam logic [SW-1:0] LAST      = SW'(FRAME_LEN - 1);

  tdm_state_e       state, state_d;
  logic [SW-1:0]    cnt, cnt_d;
  logic [LANES-1:0] shadow, shadow_d;
  logic [LANES-1:0] lanes_d;
  logic             frame_vld_d, sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
  logic             parity_err_d;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_d;
  end

  // NOTE: every signal gets a default first so no path through this block infers a latch.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    shadow_d    = shadow;
    lanes_d     = lanes;
    frame_vld_d = 1'b0;
    sync_err_d  = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    parity_err_d = 1'b0;
`endif
    if (din_vld) begin
      unique case (state)
        HUNT: begin
          if (fsync) begin
            shadow_d[0] = din;
            cnt_d       = SW'(1);
            state_d     = LOCKED;
          end
        end
        LOCKED: begin
          if (cnt == '0) begin
            if (fsync) begin
              shadow_d[0] = din;
              cnt_d       = SW'(1);
            end else begin
              sync_err_d = 1'b1;
              state_d    = HUNT;
            end
          end else if (fsync) begin
            // Misaligned marker: drop the partial frame and realign on this bit.
            sync_err_d  = 1'b1;
            shadow_d[0] = din;
            cnt_d       = SW'(1);
          end else if (cnt == LAST) begin
            cnt_d       = '0;
            frame_vld_d = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
            lanes_d      = shadow;
            parity_err_d = ^{shadow, din};
`else
            lanes_d      = {din, shadow[LANES-2:0]};
`endif
          end else begin
            for (int i = 0; i < LANES; i++) begin
              if (cnt == SW'(i)) shadow_d[i] = din;
            end
            cnt_d = cnt + SW'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // NOTE: the shadow is reset along with the rest so a relock never exposes stale bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      shadow    <= '0;
      lanes     <= '0;
      frame_vld <= 1'b0;
      sync_err  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      cnt       <= cnt_d;
      shadow    <= shadow_d;
      lanes     <= lanes_d;
      frame_vld <= frame_vld_d;
      sync_err  <= sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
      parity_err <= parity_err_d;
`endif
    end
  end

  always_comb begin
    locked = (state == LOCKED);
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux (LANES=4), covering both TDM_DEMUX_PARITY_EN builds.
module tb_tdm_demux;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       din_vld;
  logic       fsync;
  logic [3:0] lanes;
  logic       frame_vld;
  logic       locked;
  logic       sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic       parity_err;
`endif

  int total = 0;
  int bad   = 0;

  tdm_demux #(.LANES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_vld   (din_vld),
    .fsync     (fsync),
    .lanes     (lanes),
    .frame_vld (frame_vld),
    .locked    (locked),
`ifdef TDM_DEMUX_PARITY_EN
    .parity_err(parity_err),
`endif
    .sync_err  (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample just after the edge that consumed them.
  task automatic step(input logic v, input logic f, input logic d);
    din_vld = v;
    fsync   = f;
    din     = d;
    @(posedge clk);
    #1;
  endtask

  // Full-rate frame starting at slot 0; flip=1 sends a wrong parity bit.
  task automatic send_frame(input logic [3:0] data, input logic flip, input string tag);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i == 0), data[i]);
      if (i < FL - 1) check({tag, "_early_vld"}, frame_vld, 0);
    end
`ifdef TDM_DEMUX_PARITY_EN
    step(1'b1, 1'b0, (^data) ^ flip);
    check({tag, "_perr"}, parity_err, flip);
`endif
    check({tag, "_vld"}, frame_vld, 1);
    check({tag, "_lanes"}, lanes, data);
  endtask

  initial begin
    rst_n = 1'b0; din = 1'b0; din_vld = 1'b0; fsync = 1'b0;
    #12;
    check("rst_lanes", lanes, 0);
    check("rst_vld", frame_vld, 0);
    check("rst_serr", sync_err, 0);
    check("rst_locked", locked, 0);
`ifdef TDM_DEMUX_PARITY_EN
    check("rst_perr", parity_err, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Hunting: bits without fsync are ignored.
    step(1'b1, 1'b0, 1'b1);
    check("hunt_locked", locked, 0);

    // First frame 1,0,1,1 -> 4'b1101.
    step(1'b1, 1'b1, 1'b1);
    check("t1_locked", locked, 1);
    check("t1_vld0", frame_vld, 0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
`ifdef TDM_DEMUX_PARITY_EN
    check("t1_vld_pre_par", frame_vld, 0);
    step(1'b1, 1'b0, 1'b1);
    check("t1_perr", parity_err, 0);
`endif
    check("t1_vld", frame_vld, 1);
    check("t1_lanes", lanes, 4'b1101);
    step(1'b0, 1'b0, 1'b0);
    check("t1_vld_pulse", frame_vld, 0);
    check("t1_hold", lanes, 4'b1101);

    // Back-to-back frames at full rate.
    send_frame(4'hA, 1'b0, "b2b_a");
    send_frame(4'h5, 1'b0, "b2b_5");

    // Stall of 3 cycles between slots 1 and 2: 4'b0110.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    repeat (3) begin
      step(1'b0, 1'b1, 1'b0);
      check("stall_vld", frame_vld, 0);
    end
    step(1'b1, 1'b0, 1'b1);
    check("stall_slot2_vld", frame_vld, 0);
    step(1'b1, 1'b0, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
    step(1'b1, 1'b0, 1'b0);
`endif
    check("stall_vld", frame_vld, 1);
    check("stall_lanes", lanes, 4'b0110);

    // fsync at slot 2: error, realign to that bit, new frame 4'b1001.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("mis_serr", sync_err, 1);
    check("mis_vld", frame_vld, 0);
    check("mis_lanes", lanes, 4'b0110);
    check("mis_locked", locked, 1);
    step(1'b1, 1'b0, 1'b0);
    check("mis_serr_pulse", sync_err, 0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
`ifdef TDM_DEMUX_PARITY_EN
    step(1'b1, 1'b0, 1'b0);
`endif
    check("realign_vld", frame_vld, 1);
    check("realign_lanes", lanes, 4'b1001);

    // Missing fsync at slot 0: error and drop to HUNT.
    step(1'b1, 1'b0, 1'b1);
    check("nosync_serr", sync_err, 1);
    check("nosync_locked", locked, 0);
    step(1'b1, 1'b0, 1'b1);
    check("nosync_serr_pulse", sync_err, 0);
    check("nosync_hunt", locked, 0);
    step(1'b1, 1'b0, 1'b0);
    check("nosync_vld", frame_vld, 0);
    send_frame(4'h3, 1'b0, "relock");
    check("relock_locked", locked, 1);

    // fsync on the final slot of the frame: misaligned, no frame.
    for (int i = 0; i < FL - 1; i++) step(1'b1, (i == 0), 1'b1);
    step(1'b1, 1'b1, 1'b0);
    check("last_serr", sync_err, 1);
    check("last_vld", frame_vld, 0);
    check("last_lanes", lanes, 4'h3);
    check("last_locked", locked, 1);

    // Asynchronous reset mid-frame clears everything immediately.
    step(1'b1, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_lanes", lanes, 0);
    check("arst_locked", locked, 0);
    check("arst_vld", frame_vld, 0);
    check("arst_serr", sync_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    check("arst_hunt", locked, 0);

`ifdef TDM_DEMUX_PARITY_EN
    send_frame(4'b0111, 1'b0, "par_ok");
    send_frame(4'b0111, 1'b1, "par_bad");
`else
    send_frame(4'hC, 1'b0, "post_rst");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
